// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cache fill controller: FSM encoding, block
// geometry defaults and the memory read latency seen by the benches.
package mem_ctrl_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam int DEF_BLOCK_WORDS = 8;
  localparam int MEM_RD_LAT      = 4;

  // Width of a word index within a block.
  function automatic int off_w(input int block_words);
    return (block_words > 1) ? $clog2(block_words) : 1;
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Clearable up-counter with a terminal-count flag; used for both the
// read-issue count and the returned-word count of a block fill.
module fill_counter #(
  parameter int W    = 4,
  parameter int TERM = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (inc)     cnt <= cnt + W'(1);
  end

  assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/mem_fill_ctrl.sv
// Cache block fill controller: streams one block of reads to memory on a
// miss, forwards returned words to the data array, and passes write-through.
module mem_fill_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_detected,
  input  logic [ADDR_WIDTH-1:0]         miss_address,
  input  logic                          wr_req,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [15:0]                   wr_data,
  input  logic [15:0]                   mem_data_out,
  input  logic                          mem_data_valid,
  output logic                          mem_enable,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [15:0]                   mem_data_in,
  output logic                          fsm_busy,
  output logic                          write_data_array,
  output logic [off_w(BLOCK_WORDS)-1:0] word_offset,
  output logic [15:0]                   fill_data,
  output logic                          write_tag_array,
  output logic                          fill_done,
  output logic                          wr_ack
);

  localparam int OFF_W = off_w(BLOCK_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      issue_cnt;
  logic [OFF_W-1:0]      ret_cnt;
  logic                  issue_tc, ret_tc;
  logic                  fill, issue_go, ret_go, last_ret, wr_go, cnt_clr;

  assign fill     = (state == ST_FILL);
  assign cnt_clr  = (state == ST_IDLE);
  assign issue_go = fill && !issue_tc;
  assign ret_go   = fill && mem_data_valid;
  assign last_ret = ret_go && ret_tc;
  assign wr_go    = !fill && wr_req && !miss_detected;

  // Issue count saturates at BLOCK_WORDS, which is what stops the read stream.
  fill_counter #(.W(CNT_W), .TERM(BLOCK_WORDS)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .inc   (issue_go),
    .cnt   (issue_cnt),
    .tc    (issue_tc)
  );

  // Return count wraps to 0 on the final word; IDLE clears it anyway.
  fill_counter #(.W(OFF_W), .TERM(BLOCK_WORDS - 1)) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .inc   (ret_go),
    .cnt   (ret_cnt),
    .tc    (ret_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      base  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (miss_detected) begin
          state <= ST_FILL;
          base  <= miss_address & ~BLK_MASK;
        end
        ST_FILL: if (last_ret) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every output is forced low while rst is held, including the
  // cycle in which a synchronous reset is still waiting for its edge.
  always_comb begin
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_data_in      = '0;
    wr_ack           = 1'b0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    word_offset      = '0;
    fill_data        = '0;
    fill_done        = 1'b0;
    write_tag_array  = 1'b0;
    if (!rst) begin
      if (issue_go) begin
        mem_enable = 1'b1;
        mem_addr   = base | ADDR_WIDTH'({issue_cnt[OFF_W-1:0], 1'b0});
      end else if (wr_go) begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr;
        mem_data_in = wr_data;
        wr_ack      = 1'b1;
      end
      fsm_busy         = fill;
      write_data_array = ret_go;
      word_offset      = ret_cnt;
      fill_data        = mem_data_out;
      fill_done        = last_ret;
      write_tag_array  = last_ret;
    end
  end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Bench for mem_fill_ctrl: a fixed-latency memory model answers reads and
// every fill is checked cycle by cycle against the block timing rules.
module tb_mem_fill_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW   = 16;
  localparam int BW   = 8;
  localparam int OW   = $clog2(BW);
  localparam int LAST = BW + MEM_RD_LAT;

  logic          clk = 1'b0, rst = 1'b1;
  logic          miss_detected = 1'b0, wr_req = 1'b0, mem_data_valid = 1'b0;
  logic [AW-1:0] miss_address = '0, wr_addr = '0;
  logic [15:0]   wr_data = '0, mem_data_out = '0;
  logic          mem_enable, mem_wr, fsm_busy, write_data_array;
  logic          write_tag_array, fill_done, wr_ack;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data_in, fill_data;
  logic [OW-1:0] word_offset;

  always #5 clk = ~clk;

  mem_fill_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .fsm_busy(fsm_busy), .write_data_array(write_data_array), .word_offset(word_offset),
    .fill_data(fill_data), .write_tag_array(write_tag_array), .fill_done(fill_done),
    .wr_ack(wr_ack)
  );

  typedef struct { int a; int due; } rd_t;

  int          ncmp = 0, nbad = 0, cyc = 0;
  logic [15:0] mem [int];
  rd_t         pend[$];
  bit          stray = 1'b0;
  logic [15:0] first_word;

  function automatic logic [15:0] rd(input int a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Present this cycle's memory return (or a forced stray pulse), then settle.
  task automatic settle();
    mem_data_valid = 1'b0;
    mem_data_out   = 16'($urandom);
    if (stray) begin
      mem_data_valid = 1'b1;
      stray = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = rd(pend[0].a);
      void'(pend.pop_front());
    end
    #1;
  endtask

  // The memory shares the reset, so outstanding reads are dropped with it.
  task automatic adv();
    if (rst) pend.delete();
    else if (mem_enable && !mem_wr) pend.push_back('{a: int'(mem_addr), due: cyc + MEM_RD_LAT});
    else if (mem_enable && mem_wr) mem[int'(mem_addr)] = mem_data_in;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_zero(input string tag, input bit in_rst);
    chk({tag, "_ctl"}, 32'({mem_enable, mem_wr, fsm_busy, write_data_array, word_offset,
                            fill_done, write_tag_array, wr_ack}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_data_in), 32'd0);
    if (in_rst) chk({tag, "_fdata"}, 32'(fill_data), 32'd0);
  endtask

  task automatic chk_write(input string tag, input logic [AW-1:0] a, input logic [15:0] d);
    chk({tag, "_en"},   32'(mem_enable), 32'd1);
    chk({tag, "_wr"},   32'(mem_wr), 32'd1);
    chk({tag, "_ack"},  32'(wr_ack), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_data_in), 32'(d));
  endtask

  // Miss presented in the current (IDLE) cycle t; returns at t+LAST+1 in IDLE.
  task automatic run_fill(input logic [AW-1:0] addr);
    int base, w;
    base = int'(addr) & ~(2 * BW - 1);
    miss_detected = 1'b1;
    miss_address  = addr;
    settle();
    chk("t0_busy", 32'(fsm_busy), 32'd0);
    chk("t0_en",   32'(mem_enable), 32'd0);
    chk("t0_ack",  32'(wr_ack), 32'd0);
    adv();
    for (int k = 1; k <= LAST; k++) begin
      settle();
      w = k - MEM_RD_LAT - 1;
      chk("busy",    32'(fsm_busy), 32'd1);
      chk("rd_en",   32'(mem_enable), 32'(k <= BW));
      chk("rd_wr",   32'(mem_wr), 32'd0);
      chk("rd_addr", 32'(mem_addr), (k <= BW) ? 32'(base + 2 * (k - 1)) : 32'd0);
      chk("wda",     32'(write_data_array), 32'(w >= 0));
      if (w >= 0) begin
        chk("offset",    32'(word_offset), 32'(w));
        chk("fill_data", 32'(fill_data), 32'(rd(base + 2 * w)));
        if (w == 0) first_word = fill_data;
      end
      chk("fill_done", 32'(fill_done), 32'(k == LAST));
      chk("tag_wr",    32'(write_tag_array), 32'(k == LAST));
      chk("fill_ack",  32'(wr_ack), 32'd0);
      adv();
    end
    miss_detected = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a, wa;
    logic [15:0]   d;

    // Reset holds every output low even with requests asserted.
    rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h1234;
    wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'h5555; stray = 1'b1;
    for (int i = 0; i < 3; i++) begin settle(); chk_zero("rst", 1'b1); adv(); end
    rst = 1'b0; miss_detected = 1'b0; wr_req = 1'b0;
    settle(); chk_zero("idle", 1'b0); adv();

    // Stray return in IDLE is ignored.
    stray = 1'b1; settle();
    chk("stray_wda",  32'(write_data_array), 32'd0);
    chk("stray_off",  32'(word_offset), 32'd0);
    chk("stray_busy", 32'(fsm_busy), 32'd0);
    adv();

    run_fill(16'h1236);
    settle(); chk("post_fill_busy", 32'(fsm_busy), 32'd0); chk_zero("post_fill", 1'b0); adv();

    // Write-through, then read it back via a fill.
    wr_req = 1'b1; wr_addr = 16'h0040; wr_data = 16'hBEEF;
    settle(); chk_write("wr40", 16'h0040, 16'hBEEF); adv();
    wr_req = 1'b0;
    run_fill(16'h0040);
    chk("beef_back", 32'(first_word), 32'h0000BEEF);

    // Miss and write together: miss wins, write acked once IDLE again.
    a  = 16'($urandom);
    wa = 16'($urandom) & 16'hFFFE; d = 16'($urandom);
    wr_req = 1'b1; wr_addr = wa; wr_data = d;
    run_fill(a);
    settle(); chk_write("wr_after_fill", wa, d); adv();
    wr_req = 1'b0;

    // Back-to-back misses.
    run_fill(16'($urandom));
    run_fill(16'($urandom));
    settle(); chk("b2b_idle", 32'(fsm_busy), 32'd0); adv();

    // Reset in the middle of a fill aborts it.
    miss_detected = 1'b1; miss_address = 16'h2A5C;
    settle(); adv();
    for (int k = 1; k <= 5; k++) begin
      settle(); chk("abort_rd", 32'(mem_addr), 32'(16'h2A50 + 2 * (k - 1))); adv();
    end
    rst = 1'b1;
    settle(); chk_zero("mid_rst", 1'b1); adv();
    rst = 1'b0; miss_detected = 1'b0; stray = 1'b1;
    settle();
    chk("abort_busy", 32'(fsm_busy), 32'd0);
    chk("abort_wda",  32'(write_data_array), 32'd0);
    chk("abort_done", 32'(fill_done), 32'd0);
    adv();
    run_fill(16'h7F02);

    // Randomized: writes into the next block, then fill it.
    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wa = (a & ~16'(2 * BW - 1)) | 16'(2 * $urandom_range(0, BW - 1));
        d  = 16'($urandom);
        wr_req = 1'b1; wr_addr = wa; wr_data = d;
        settle(); chk_write("rnd_wr", wa, d); adv();
        wr_req = 1'b0;
      end
      run_fill(a);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        settle(); chk_zero("rnd_gap", 1'b0); adv();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte-address width of the memory port.
REQ-002 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block; power of two, 2..16.
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 miss_detected  in  1  cache miss request; held high by the cache until fill_done.
REQ-006 miss_address  in  ADDR_WIDTH  byte address of the missing access.
REQ-007 wr_req  in  1  single-word write-through request.
REQ-008 wr_addr  in  ADDR_WIDTH  write byte address, bit 0 = 0.
REQ-009 wr_data  in  16  write data.
REQ-010 mem_data_out  in  16  read data returned by memory.
REQ-011 mem_data_valid  in  1  mem_data_out valid this cycle.
REQ-012 mem_enable  out  1  memory access strobe.
REQ-013 mem_wr  out  1  1 = write, 0 = read.
REQ-014 mem_addr  out  ADDR_WIDTH  memory byte address.
REQ-015 mem_data_in  out  16  memory write data.
REQ-016 fsm_busy  out  1  fill in progress.
REQ-017 write_data_array  out  1  fill_data is to be written at word_offset.
REQ-018 word_offset  out  log2(BLOCK_WORDS)  word index within the block for fill_data.
REQ-019 fill_data  out  16  word to write into the cache data array.
REQ-020 write_tag_array / fill_done  out  1 each  single-cycle pulse on final word.
REQ-021 wr_ack  out  1  write accepted this cycle.

Function
REQ-022 FSM states: IDLE, FILL; each transition occurs on the clk edge.
REQ-023 IDLE -> FILL occurs when miss_detected=1; block base = miss_address with low log2(BLOCK_WORDS*2) bits cleared, registered on entry.
REQ-024 In FILL, while issue_cnt < BLOCK_WORDS: mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments each cycle, so one read is issued per cycle with no gaps.
REQ-025 Returned words are counted by ret_cnt, which increments on each mem_data_valid in FILL; write_data_array=mem_data_valid, fill_data=mem_data_out, word_offset=ret_cnt, all combinational.
REQ-026 Memory returns data 4 cycles after each read, in issue order; the controller relies only on mem_data_valid, not on a fixed latency.
REQ-027 On the mem_data_valid with ret_cnt=BLOCK_WORDS-1: fill_done=write_tag_array=1 for that cycle; FILL -> IDLE.
REQ-028 fsm_busy = (state==FILL).
REQ-029 Timing for miss seen in IDLE cycle t (BLOCK_WORDS=8): reads t+1..t+8, valid t+5..t+12, fill_done t+12, IDLE at t+13.
REQ-030 Write: in IDLE with wr_req=1 and miss_detected=0: mem_enable=1, mem_wr=1, mem_addr=wr_addr, mem_data_in=wr_data, wr_ack=1, all in the same cycle.
REQ-031 If miss_detected and wr_req are both high in IDLE, the miss wins; wr_ack=0 and the write waits.
REQ-032 wr_req during FILL: wr_ack=0; there are no memory writes during a fill.
REQ-033 mem_data_valid in IDLE is ignored: no write_data_array, no counter change.
REQ-034 Counters wrap only by reset to 0 on FILL entry; issue_cnt saturates at BLOCK_WORDS (no further reads).
REQ-035 When no access is active: mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0.

Reset
REQ-036 rst sets state=IDLE, issue_cnt=0, ret_cnt=0, base=0; rst takes priority over all other inputs.
REQ-037 While rst=1, all outputs are 0.
REQ-038 rst mid-FILL aborts the fill: no fill_done, and in-flight returns after reset are ignored under REQ-033.

Structure
REQ-039 Shared package mem_ctrl_pkg holds: state encoding, the BLOCK_WORDS default, the offset-width function, and the memory read latency constant (4) used by benches.
REQ-040 Sub-module fill_counter (clear, increment, terminal-count flag) is instantiated twice, for issue_cnt and ret_cnt.

Verification
REQ-041 Miss at 0x1236 in cycle t -> reads 0x1230..0x123E at t+1..t+8, word_offset 0..7 at t+5..t+12, fill_done=1 only at t+12.
REQ-042 wr_req addr 0x0040 data 0xBEEF in IDLE -> same-cycle mem_enable=1, mem_wr=1, wr_ack=1; a later fill of 0x0040 returns 0xBEEF at offset 0.
REQ-043 miss_detected and wr_req high together -> fill first, wr_ack=0 throughout; write acked at t+13.
REQ-044 rst asserted at t+6 of a fill -> outputs 0, state IDLE, no fill_done; a new miss at t+8 completes a clean 12-cycle fill.
REQ-045 Stray mem_data_valid pulse in IDLE -> write_data_array stays 0 and counters stay 0.
REQ-046 Back-to-back misses (new miss at t+13) -> second fill starts at t+14 with issue_cnt and ret_cnt restarting at 0.
